// File: rtl/game_pkg.sv
// game_pkg: shared constants, FSM state encoding and the spawn interval helper
// for the game sequencer.
package game_pkg;

  localparam int V_ACTIVE    = 480;
  localparam int H_ACTIVE    = 640;
  localparam int N_SLOTS_DEF = 3;

  // Encoding is visible on the debug LEDs, so the values are fixed.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    DEAD  = 3'd3,
    OVER  = 3'd4
  } state_t;

  // Reload interval: max(base - lvl*step, floor) in 8-bit unsigned, never
  // allowed to wrap below zero.
  function automatic logic [7:0] spawn_interval(input logic [2:0] lvl,
                                                input int base,
                                                input int step,
                                                input int floor_v);
    logic [7:0] b, d, f;
    b = 8'(base);
    d = 8'(int'(lvl) * step);
    f = 8'(floor_v);
    if (b > d && (b - d) > f) return b - d;
    return f;
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// game_sequencer_if: bundle between the game top level and the sequencer.
// slave = the sequencer, master = the surrounding game logic.
// With GAME_SEQ_INVINCIBLE_EN defined the bundle carries the invincible input.
interface game_sequencer_if #(
  parameter int N_SLOTS = game_pkg::N_SLOTS_DEF
) ();

  logic [9:0]         vaddress;
  logic [9:0]         haddress;
  logic [3:0]         btn;
  logic               hit;
  logic [N_SLOTS-1:0] slot_busy;
  logic               halt;
  logic               game_reset;
  logic               frame_tick;
  logic [N_SLOTS-1:0] spawn_en;
  logic [2:0]         level;
  logic               dead;
  logic [2:0]         state;

`ifdef GAME_SEQ_INVINCIBLE_EN
  logic               invincible;

  modport slave (
    input  vaddress, haddress, btn, hit, slot_busy, invincible,
    output halt, game_reset, frame_tick, spawn_en, level, dead, state
  );
  modport master (
    output vaddress, haddress, btn, hit, slot_busy, invincible,
    input  halt, game_reset, frame_tick, spawn_en, level, dead, state
  );
`else
  modport slave (
    input  vaddress, haddress, btn, hit, slot_busy,
    output halt, game_reset, frame_tick, spawn_en, level, dead, state
  );
  modport master (
    output vaddress, haddress, btn, hit, slot_busy,
    input  halt, game_reset, frame_tick, spawn_en, level, dead, state
  );
`endif

endinterface

// File: rtl/game_sequencer_btn_qualifier.sv
// btn_qualifier: frame-sampled button debounce.
// press pulses on the tick where any button has been down for DEBOUNCE_FRAMES
// consecutive ticks (once per hold); rel pulses on any tick with all buttons up.
module btn_qualifier #(
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] btn,
  output logic       press,
  output logic       rel
);

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

  logic [CW-1:0] hold_cnt;
  logic          any_btn;

  assign any_btn = |btn;

  // Consecutive held frames, saturating past the threshold so a long hold
  // yields a single press.
  always_ff @(posedge clk) begin
    if (!reset) hold_cnt <= '0;
    else if (tick) begin
      if (!any_btn) hold_cnt <= '0;
      else if (hold_cnt != CW'(DEBOUNCE_FRAMES)) hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign press = tick && any_btn && (hold_cnt == CW'(DEBOUNCE_FRAMES - 1));
  assign rel   = tick && !any_btn;

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: game-flow FSM, round-robin asteroid spawn scheduler and
// difficulty level counter. All outputs are registered.
// Optional: GAME_SEQ_INVINCIBLE_EN adds bus.invincible, which masks hit.
module game_sequencer #(
  parameter int N_SLOTS         = game_pkg::N_SLOTS_DEF,
  parameter int V_ACTIVE        = game_pkg::V_ACTIVE,
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int DEAD_FRAMES     = 60,
  parameter int SPAWN_BASE      = 90,
  parameter int SPAWN_STEP      = 8,
  parameter int SPAWN_MIN       = 20,
  parameter int LEVEL_FRAMES    = 600,
  parameter int MAX_LEVEL       = 7
) (
  input logic             clk,
  input logic             reset,
  game_sequencer_if.slave bus
);
  import game_pkg::*;

  localparam int PW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int IW = PW + 1;
  localparam int DW = $clog2(DEAD_FRAMES + 1);
  localparam int FW = $clog2(LEVEL_FRAMES + 1);

  state_t             state_q, state_d;
  logic               ft, press, rel, hit_eff, run_live, spawn_fire, found;
  logic               rel_seen_q;
  logic [IW-1:0]      idx;
  logic [PW-1:0]      ptr_q, slot, slot_nxt;
  logic [7:0]         cd_q;
  logic [FW-1:0]      fc_q;
  logic [DW-1:0]      dcnt_q;
  logic [2:0]         level_q;
  logic               halt_q, game_reset_q, frame_tick_q, dead_q;
  logic [N_SLOTS-1:0] spawn_en_q;

  assign ft = (bus.vaddress == 10'(V_ACTIVE)) && (bus.haddress == 10'd0);

  btn_qualifier #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_btn (
    .clk   (clk),
    .reset (reset),
    .tick  (ft),
    .btn   (bus.btn),
    .press (press),
    .rel   (rel)
  );

`ifdef GAME_SEQ_INVINCIBLE_EN
  assign hit_eff = bus.hit && !bus.invincible;
`else
  assign hit_eff = bus.hit;
`endif

  // A hit freezes all RUN bookkeeping on the cycle it lands.
  assign run_live = (state_q == RUN) && !hit_eff;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (press) state_d = START;
      START:   state_d = RUN;
      RUN:     if (hit_eff) state_d = DEAD;
      DEAD:    if (ft && dcnt_q == DW'(DEAD_FRAMES - 1)) state_d = OVER;
      OVER:    if (press && rel_seen_q) state_d = START;
      default: state_d = IDLE;
    endcase
  end

  // First free slot at or after the round-robin pointer, wrapping.
  always_comb begin
    found = 1'b0;
    slot  = '0;
    idx   = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      idx = IW'(ptr_q) + IW'(i);
      if (idx >= IW'(N_SLOTS)) idx = idx - IW'(N_SLOTS);
      if (!found && !bus.slot_busy[idx[PW-1:0]]) begin
        found = 1'b1;
        slot  = idx[PW-1:0];
      end
    end
  end

  assign slot_nxt   = (slot == PW'(N_SLOTS - 1)) ? '0 : slot + 1'b1;
  assign spawn_fire = run_live && (cd_q == 8'd0) && found;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Spawn countdown, round-robin pointer and level progression.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cd_q    <= '0;
      ptr_q   <= '0;
      fc_q    <= '0;
      level_q <= '0;
    end else if (state_q == START) begin
      cd_q    <= 8'(SPAWN_BASE);
      ptr_q   <= '0;
      fc_q    <= '0;
      level_q <= '0;
    end else if (run_live) begin
      // The countdown holds at 0 while every slot is busy.
      if (spawn_fire) begin
        cd_q  <= spawn_interval(level_q, SPAWN_BASE, SPAWN_STEP, SPAWN_MIN);
        ptr_q <= slot_nxt;
      end else if (ft && cd_q != 8'd0) begin
        cd_q <= cd_q - 8'd1;
      end
      if (ft) begin
        if (fc_q == FW'(LEVEL_FRAMES - 1)) begin
          fc_q <= '0;
          if (level_q != 3'(MAX_LEVEL)) level_q <= level_q + 3'd1;
        end else begin
          fc_q <= fc_q + 1'b1;
        end
      end
    end
  end

  // Death hold timer and the release seen since entering OVER.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dcnt_q     <= '0;
      rel_seen_q <= 1'b0;
    end else begin
      if (state_q != DEAD) dcnt_q <= '0;
      else if (ft)         dcnt_q <= dcnt_q + 1'b1;
      rel_seen_q <= (state_q == OVER) && (rel_seen_q || rel);
    end
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      halt_q       <= 1'b1;
      game_reset_q <= 1'b0;
      dead_q       <= 1'b0;
      frame_tick_q <= 1'b0;
      spawn_en_q   <= '0;
    end else begin
      halt_q       <= (state_d != RUN);
      game_reset_q <= (state_d == START);
      dead_q       <= (state_d == DEAD) || (state_d == OVER);
      frame_tick_q <= ft;
      spawn_en_q   <= spawn_fire ? (N_SLOTS'(1) << slot) : '0;
    end
  end

  assign bus.halt       = halt_q;
  assign bus.game_reset = game_reset_q;
  assign bus.dead       = dead_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.spawn_en   = spawn_en_q;
  assign bus.level      = level_q;
  assign bus.state      = state_q;

endmodule
